input_conditioner: RTL

Synthesizable, parametrised input front-end for board buttons and switches. It is the RTL successor to the bench-only input model and sits between raw pads and the control logic. Each of IW channels is synchronised, debounced and polarity-normalised. Each channel also emits single-cycle press, release, long-press and auto-repeat events, all timed from one shared prescaler tick.

---
 rtl/input_cond_pkg.sv | 18 +
 rtl/input_cond_ch.sv | 153 +++++++++++++++
 rtl/input_conditioner.sv | 69 ++++++
 3 files changed

// File: rtl/input_cond_pkg.sv
// Shared types and helpers for the input conditioner.
// Latency: n/a (package only).
// Backpressure: n/a.
package input_cond_pkg;

  // Per-channel hold tracker states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } hold_state_t;

  // Bits needed to hold values 0..max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/input_cond_ch.sv
// One pad channel: synchroniser, tick-based debounce, edge events, hold/repeat tracker.
// Latency: SYNC clocks of synchronisation plus DB_CNT ticks of debounce; all outputs registered.
// Backpressure: none; pads are sampled every clock and events are fire-and-forget pulses.
module input_cond_ch
  import input_cond_pkg::*;
#(
  parameter int   SYNC   = 2,
  parameter logic DS_BIT = 1'b0,
  parameter int   DB_CNT = 4,
  parameter int   LP_CNT = 8,
  parameter int   RP_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_i,
  input  logic tick_i,
  output logic o_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic rpt_o
);

  localparam int DBW = cnt_w(DB_CNT);
  localparam int HW  = cnt_w((LP_CNT > RP_CNT) ? LP_CNT : RP_CNT);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CNT - 1);
  localparam logic [HW-1:0]  LP_MAX = HW'(LP_CNT - 1);
  // Only consulted when repeat is enabled (RP_CNT != 0).
  localparam logic [HW-1:0]  RP_MAX = HW'(RP_CNT - 1);

  logic [SYNC-1:0] sync_q;
  logic            act;
  logic [DBW-1:0]  db_cnt_q, db_cnt_d;
  logic            toggle;
  logic            o_q, o_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;
  logic            rpt_q, rpt_d;
  hold_state_t     state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic            parked_q, parked_d;

  // Synchroniser preloads the idle level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC{DS_BIT}};
    else        sync_q <= {sync_q[SYNC-2:0], pad_i};
  end

  // Active-high view of the pad regardless of pad polarity.
  assign act = sync_q[SYNC-1] ^ DS_BIT;

  // Debounce: count mismatching ticks, any agreeing clock restarts the count.
  always_comb begin
    db_cnt_d = db_cnt_q;
    toggle   = 1'b0;
    if (act == o_q) begin
      db_cnt_d = '0;
    end else if (tick_i) begin
      if (db_cnt_q == DB_MAX) begin
        toggle   = 1'b1;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign o_d       = o_q ^ toggle;
  assign press_d   = toggle & ~o_q;
  assign release_d = toggle & o_q;

  // Hold tracker: long after LP_CNT ticks held, then rpt every RP_CNT ticks.
  always_comb begin
    state_d  = state_q;
    h_cnt_d  = h_cnt_q;
    parked_d = parked_q;
    long_d   = 1'b0;
    rpt_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_d) begin
          state_d  = HOLD;
          h_cnt_d  = '0;
          parked_d = 1'b0;
        end
      end
      HOLD: begin
        if (tick_i && !parked_q) begin
          if (h_cnt_q == LP_MAX) begin
            long_d  = 1'b1;
            h_cnt_d = '0;
            if (RP_CNT != 0) state_d  = RPT;
            else             parked_d = 1'b1;
          end else begin
            h_cnt_d = h_cnt_q + 1'b1;
          end
        end
      end
      RPT: begin
        if (tick_i) begin
          if (h_cnt_q == RP_MAX) begin
            rpt_d   = 1'b1;
            h_cnt_d = '0;
          end else begin
            h_cnt_d = h_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Released (or never pressed): drop back to idle and suppress events this cycle.
    if (!o_d) begin
      state_d  = IDLE;
      h_cnt_d  = '0;
      parked_d = 1'b0;
      long_d   = 1'b0;
      rpt_d    = 1'b0;
    end
  end

  // State, counters and registered event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q  <= '0;
      o_q       <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      rpt_q     <= 1'b0;
      state_q   <= IDLE;
      h_cnt_q   <= '0;
      parked_q  <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      o_q       <= o_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      rpt_q     <= rpt_d;
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      parked_q  <= parked_d;
    end
  end

  assign o_o       = o_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign rpt_o     = rpt_q;

endmodule

// File: rtl/input_conditioner.sv
// Button/switch front-end: shared prescaler tick plus IW independent conditioned channels.
// Latency: SYNC + up to PRE*DB_CNT clocks from pad change to o/press/release.
// Backpressure: none; outputs are level state and single-cycle pulses.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int            IW     = 1,
  parameter logic [IW-1:0] DS     = {IW{1'b0}},
  parameter int            SYNC   = 2,
  parameter int            PRE    = 1,
  parameter int            DB_CNT = 4,
  parameter int            LP_CNT = 8,
  parameter int            RP_CNT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] i_i,
  output logic [IW-1:0] o_o,
  output logic [IW-1:0] press_o,
  output logic [IW-1:0] release_o,
  output logic [IW-1:0] long_o,
  output logic [IW-1:0] rpt_o
);

  // Parameter sanity: a bad configuration must not elaborate.
  if (IW < 1)     begin : g_bad_iw   $error("input_conditioner: IW must be >= 1");     end
  if (SYNC < 2)   begin : g_bad_sync $error("input_conditioner: SYNC must be >= 2");   end
  if (PRE < 1)    begin : g_bad_pre  $error("input_conditioner: PRE must be >= 1");    end
  if (DB_CNT < 1) begin : g_bad_db   $error("input_conditioner: DB_CNT must be >= 1"); end
  if (LP_CNT < 1) begin : g_bad_lp   $error("input_conditioner: LP_CNT must be >= 1"); end
  if (RP_CNT < 0) begin : g_bad_rp   $error("input_conditioner: RP_CNT must be >= 0"); end

  localparam int PW = cnt_w(PRE);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRE - 1);

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic          tick;

  // Tick on the last count of each prescaler period; PRE=1 ticks every clock.
  assign tick      = (pre_cnt_q == PRE_MAX);
  assign pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;

  // Prescaler counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_cnt_q <= '0;
    else        pre_cnt_q <= pre_cnt_d;
  end

  for (genvar g = 0; g < IW; g++) begin : g_ch
    input_cond_ch #(
      .SYNC   (SYNC),
      .DS_BIT (DS[g]),
      .DB_CNT (DB_CNT),
      .LP_CNT (LP_CNT),
      .RP_CNT (RP_CNT)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .pad_i     (i_i[g]),
      .tick_i    (tick),
      .o_o       (o_o[g]),
      .press_o   (press_o[g]),
      .release_o (release_o[g]),
      .long_o    (long_o[g]),
      .rpt_o     (rpt_o[g])
    );
  end

endmodule
